// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider retiring one quotient bit per clock.
// Optional macro DIV_SIGNED_EN: two's-complement operands with a FIX sign-correction state.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    logic             accept, last, div_zero, ge;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_nx, quo_nx, dvd_mag, dvs_mag;

    // rem is held in WIDTH bits: it always stays below the divisor, so the
    // extra restoring bit only exists in the shifted trial value.
    always_comb begin
        accept   = start && (state_q == S_IDLE || state_q == S_DONE);
        last     = (cnt_q == CW'(WIDTH - 1));
        div_zero = (divisor == '0);
        shifted  = {rem_q, quo_q[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_nx   = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        quo_nx   = {quo_q[WIDTH-2:0], ge};
`ifdef DIV_SIGNED_EN
        dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
        dvd_mag  = dividend;
        dvs_mag  = divisor;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = div_zero ? S_DONE : S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN: begin
`ifdef DIV_SIGNED_EN
                if (last) state_d = S_FIX;
`else
                if (last) state_d = S_DONE;
`endif
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        q_d    = q_q;
        r_d    = r_q;
        dbz_d  = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d = qneg_q;
        rneg_d = rneg_q;
`endif
        if (accept) begin
            cnt_d = '0;
            rem_d = '0;
            quo_d = dvd_mag;
            dvs_d = dvs_mag;
`ifdef DIV_SIGNED_EN
            qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d = dividend[WIDTH-1];
`endif
            if (div_zero) begin
                q_d   = '1;
                r_d   = dividend;
                dbz_d = 1'b1;
            end
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CW'(1);
            rem_d = rem_nx;
            quo_d = quo_nx;
`ifndef DIV_SIGNED_EN
            if (last) begin
                q_d   = quo_nx;
                r_d   = rem_nx;
                dbz_d = 1'b0;
            end
`endif
        end
`ifdef DIV_SIGNED_EN
        else if (state_q == S_FIX) begin
            q_d   = qneg_q ? -quo_q : quo_q;
            r_d   = rneg_q ? -rem_q : rem_q;
            dbz_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            q_q    <= q_d;
            r_q    <= r_d;
            dbz_q  <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_FIX);
        done = (state_q == S_DONE);
        q    = q_q;
        r    = r_q;
        dbz  = dbz_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus literal directed cases.
module tb_seq_divider;
    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dbz;
    logic [W-1:0] q, r;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from plain arithmetic.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] eq, output logic [W-1:0] er,
                                    output logic ed);
        if (b == '0) begin
            eq = '1;
            er = a;
            ed = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa, sb;
            sa = $signed(a);
            sb = $signed(b);
            eq = W'(sa / sb);
            er = W'(sa % sb);
`else
            eq = a / b;
            er = a % b;
`endif
            ed = 1'b0;
        end
    endfunction

    // Timestamp model: expected busy/done/results from acceptance time and latency.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, acc, p_dbz;
    logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;
    int           cyc = 0, done_at = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
        end else begin
            cyc    = cyc + 1;
            acc    = start && !m_busy;
            m_done = 1'b0;
            if (m_busy && cyc == done_at) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = p_q;
                m_r    = p_r;
                m_dbz  = p_dbz;
            end
            if (acc) begin
                ref_div(dividend, divisor, p_q, p_r, p_dbz);
                if (p_dbz) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_dbz  = 1'b1;
                end else begin
                    m_busy  = 1'b1;
                    done_at = cyc + LAT - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("q", q, m_q);
            check("r", r, m_r);
            check("dbz", dbz, m_dbz);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        if (!hold) begin
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
        end
    endtask

    // Counts edges from the accepting edge (edge 1) until done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 4 * LAT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", done, 1);
    endtask

    task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                          input int elat);
        int n;
        issue(a, b, 1'b0);
        wait_done(n);
        check({name, "_lat"}, n, elat);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
        check({name, "_dbz"}, dbz, ed);
        check({name, "_model_q"}, m_q, eq);
        check({name, "_model_r"}, m_r, er);
        @(posedge clk);
        #1;
        check({name, "_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [W-1:0] a, b, eq, er;
        logic         ed;

        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", dbz, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef DIV_SIGNED_EN
        op_lit("s_m7d2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 10);
        op_lit("s_7dm2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 10);
        op_lit("s_wrap", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
`else
        op_lit("u_200d7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
        op_lit("u_3d9", 8'd3, 8'd9, 8'd0, 8'd3, 1'b0, 9);
        op_lit("u_255d1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
`endif
        op_lit("dbz_5d0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1);

        // start held with new operands while busy, then through the DONE cycle
        issue(8'd100, 8'd7, 1'b1);
        dividend = 8'd50;
        divisor  = 8'd3;
        wait_done(n);
        check("hold_lat", n, LAT);
        check("hold_q1", q, 8'd14);
        check("hold_r1", r, 8'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(n);
        check("b2b_lat", n, LAT);
        check("b2b_q2", q, 8'd16);
        check("b2b_r2", r, 8'd2);
        @(posedge clk);
        #1;

        // asynchronous reset mid-run
        issue(8'd100, 8'd7, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        op_lit("after_rst", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, LAT);

        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            else                           b = W'($urandom);
            ref_div(a, b, eq, er, ed);
            op_lit("rand", a, b, eq, er, ed, ed ? 1 : LAT);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
